ifft32_iter: RTL and testbench
==============================

// Module: ifft32_iter
// PURPOSE
//  32-point complex inverse FFT. It is the receive-side inverse of the streaming 32-point FFT.
//  Accepts frequency-domain samples in natural order (16-bit, the FFT output format) and returns
//  time-domain samples in natural order (12-bit, the FFT input format), scaled by 1/32.
//  Memory-based radix-2 DIT with one butterfly unit and an FSM (LOAD/CALC/DUMP).
// PARAMETERS
//  DECIMAL   6   fractional bits of internal datapath and of twiddles (1.0 = 2^DECIMAL)
//  IN_W      16  input sample width per component
//  OUT_W     12  output sample width per component
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      din_r/din_i valid this cycle
//  din_r      in   16     signed real part, X[k], natural order
//  din_i      in   16     signed imaginary part
//  in_ready   out  1      block accepts a sample this cycle (high only in LOAD)
//  out_valid  out  1      dout_r/dout_i valid
//  dout_r     out  12     signed real part, x[n], natural order
//  dout_i     out  12     signed imaginary part
// BEHAVIOUR
//  - Reset: state=LOAD, cnt=0, buffer cleared; in_ready=1, out_valid=0, dout_r=dout_i=0.
//  - Internal word: W = IN_W+5+DECIMAL bits (27). Each input is sign-extended, then shifted left
//    by DECIMAL. The 5 guard bits absorb the x32 growth, so there is no overflow inside.
//  - LOAD: accept on in_valid&in_ready. Sample j is stored at buf[bitrev5(j)]. in_valid gaps are
//    allowed and cnt holds during them. The 32nd accept moves the FSM to CALC on the next cycle.
//  - CALC: exactly 80 cycles, one butterfly per cycle, stage s=0..4, butterfly b=0..15.
//    half=2^s, pos=b&(half-1), top=((b>>s)<<(s+1))+pos, bot=top+half, tw index=pos<<(4-s).
//    t = buf[bot]*Wc, where Wc = cos(2*pi*tw/32) + j*sin(2*pi*tw/32) is the conjugate of the
//    forward twiddle. Wc is 8-bit signed Q1.DECIMAL, and Wc[0]=64+j0.
//    Product is rounded back to DECIMAL fraction bits: round-half-up on bit DECIMAL-1.
//    buf[top] <= buf[top]+t and buf[bot] <= buf[top]-t. Read is combinational, write at the edge.
//  - DUMP: 32 consecutive cycles with out_valid=1, dout = buf[n] for n=0..31.
//    Conversion: arithmetic shift right by DECIMAL+5 (the 1/32 scale), round-half-up on the
//    last discarded bit, then reduce to OUT_W (see CONFIGURATION).
//    The cycle after n=31: out_valid=0, dout holds its last value, state=LOAD, in_ready=1.
//  - Latency: 32nd accept at cycle T gives CALC in T+1..T+80 and out_valid in T+81..T+112.
//  - in_valid during CALC/DUMP: in_ready=0 and the sample is dropped. No back-pressure on output.
//  - rst_n asserted in any state: immediate return to reset values. A partial frame is discarded.
// CONFIGURATION
//  IFFT_SAT_EN defined: output saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//  IFFT_SAT_EN undefined: output is the low OUT_W bits (two's-complement wrap).
// STRUCTURE
//  ifft32_pkg holds: N=32, LOG2N=5, state enum {LOAD,CALC,DUMP}, 16-entry conjugate twiddle ROM
//  (cos/sin, Q1.6), and a bitrev5 function.
//  ifft32_bfly is one combinational sub-module: complex multiply, rounding, add/sub. It is
//  parameterised by W and DECIMAL.
//  Top level holds the FSM, counters (cnt/stage/b), the 32xW complex register buffer and the
//  output conversion.
// TESTING
//  1 X[0]=2048+j0, others 0 -> 32 outputs of 64+j0; out_valid exactly 32 cycles, from T+81.
//  2 X[1]=3200+j0, others 0 -> x[0]=100, x[8]=+j100, x[16]=-100, x[24]=-j100; each within 1 LSB.
//  3 Round trip: random 12-bit x through the golden forward FFT (16-bit out), then this block
//    -> equals x within 2 LSB on 100 frames.
//  4 in_valid with random gaps, and held high during CALC/DUMP -> in_ready=0 there, extra
//    samples are not stored, next frame is correct.
//  5 rst_n pulsed at CALC cycle 40 -> out_valid=0 and in_ready=1 at once, buffer cleared,
//    the following frame is correct.
//  6 All X[k]=32767+j0 -> x[0]=2047 with IFFT_SAT_EN, -1 without it; x[n>0]=0 in both builds.

Source files
------------

// File: rtl/ifft32_pkg.sv
// Shared definitions for the iterative 32-point inverse FFT: sizes, FSM
// states, the conjugate twiddle ROM (Q1.6) and the bit-reversal helper.
package ifft32_pkg;

    localparam int N     = 32;
    localparam int LOG2N = 5;
    localparam int TW_W  = 8;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_CALC = 2'd1,
        ST_DUMP = 2'd2
    } state_t;

    // Wc[k] = cos(2*pi*k/32) + j*sin(2*pi*k/32), scaled by 64 and rounded.
    localparam logic signed [TW_W-1:0] TW_COS [16] = '{
        8'sd64,  8'sd63,  8'sd59,  8'sd53,  8'sd45,  8'sd36,  8'sd24,  8'sd12,
        8'sd0,  -8'sd12, -8'sd24, -8'sd36, -8'sd45, -8'sd53, -8'sd59, -8'sd63
    };
    localparam logic signed [TW_W-1:0] TW_SIN [16] = '{
        8'sd0,   8'sd12,  8'sd24,  8'sd36,  8'sd45,  8'sd53,  8'sd59,  8'sd63,
        8'sd64,  8'sd63,  8'sd59,  8'sd53,  8'sd45,  8'sd36,  8'sd24,  8'sd12
    };

    // Reverse the five address bits so natural-order input lands where DIT expects it.
    function automatic logic [LOG2N-1:0] bitrev5(input logic [LOG2N-1:0] idx);
        return {idx[0], idx[1], idx[2], idx[3], idx[4]};
    endfunction

endpackage

// File: rtl/ifft32_bfly.sv
// Radix-2 DIT butterfly: t = b*Wc rounded half-up to DECIMAL fraction bits,
// top = a + t, bot = a - t. Purely combinational.
module ifft32_bfly #(
    parameter int W       = 27,
    parameter int DECIMAL = 6
) (
    input  logic signed [W-1:0] a_re,
    input  logic signed [W-1:0] a_im,
    input  logic signed [W-1:0] b_re,
    input  logic signed [W-1:0] b_im,
    input  logic signed [7:0]   w_re,
    input  logic signed [7:0]   w_im,
    output logic signed [W-1:0] top_re,
    output logic signed [W-1:0] top_im,
    output logic signed [W-1:0] bot_re,
    output logic signed [W-1:0] bot_im
);

    // Wide enough for a W x 8 product plus the sum of two such products.
    localparam int PW = W + 9;
    localparam logic signed [PW-1:0] HALF = PW'(2 ** (DECIMAL - 1));

    logic signed [PW-1:0] prod_re_s;
    logic signed [PW-1:0] prod_im_s;
    logic signed [W-1:0]  t_re_s;
    logic signed [W-1:0]  t_im_s;

    assign prod_re_s = PW'(b_re) * PW'(w_re) - PW'(b_im) * PW'(w_im);
    assign prod_im_s = PW'(b_re) * PW'(w_im) + PW'(b_im) * PW'(w_re);

    // Guard bits guarantee the rounded product fits back into W bits.
    assign t_re_s = W'((prod_re_s + HALF) >>> DECIMAL);
    assign t_im_s = W'((prod_im_s + HALF) >>> DECIMAL);

    assign top_re = a_re + t_re_s;
    assign top_im = a_im + t_im_s;
    assign bot_re = a_re - t_re_s;
    assign bot_im = a_im - t_im_s;

endmodule

// File: rtl/ifft32_iter.sv
// Iterative 32-point inverse FFT: LOAD (bit-reversed store), CALC (80
// butterflies, one per cycle), DUMP (32 natural-order outputs scaled by 1/32).
// Build option: define IFFT_SAT_EN to saturate outputs instead of wrapping.
module ifft32_iter
    import ifft32_pkg::*;
#(
    parameter int DECIMAL = 6,
    parameter int IN_W    = 16,
    parameter int OUT_W   = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  din_r,
    input  logic signed [IN_W-1:0]  din_i,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] dout_r,
    output logic signed [OUT_W-1:0] dout_i
);

    localparam int W = IN_W + 5 + DECIMAL;

    state_t                state_r;
    state_t                next_state_s;
    logic [4:0]            cnt_r;
    logic [2:0]            stage_r;
    logic [3:0]            bfly_r;
    logic signed [W-1:0]   buf_re_r [N];
    logic signed [W-1:0]   buf_im_r [N];
    logic                  out_valid_r;
    logic signed [OUT_W-1:0] dout_re_r;
    logic signed [OUT_W-1:0] dout_im_r;

    logic                  accept_s;
    logic                  calc_last_s;
    logic [3:0]            pos_s;
    logic [4:0]            top_s;
    logic [4:0]            bot_s;
    logic [3:0]            tw_idx_s;
    logic signed [W-1:0]   ext_re_s;
    logic signed [W-1:0]   ext_im_s;
    logic signed [W-1:0]   top_re_s;
    logic signed [W-1:0]   top_im_s;
    logic signed [W-1:0]   bot_re_s;
    logic signed [W-1:0]   bot_im_s;
    logic signed [OUT_W-1:0] conv_re_s;
    logic signed [OUT_W-1:0] conv_im_s;

    // Drop the 1/32 scale and fraction bits with round-half-up, then fit OUT_W.
    function automatic logic signed [OUT_W-1:0] to_out(input logic signed [W-1:0] v);
        logic signed [W-1:0] s;
`ifdef IFFT_SAT_EN
        logic signed [W-1:0] hi;
        logic signed [W-1:0] lo;
        hi = W'(2 ** (OUT_W - 1) - 1);
        lo = W'(-(2 ** (OUT_W - 1)));
`endif
        s = (v + W'(2 ** (DECIMAL + 4))) >>> (DECIMAL + 5);
`ifdef IFFT_SAT_EN
        if (s > hi) begin
            return {1'b0, {(OUT_W - 1){1'b1}}};
        end else if (s < lo) begin
            return {1'b1, {(OUT_W - 1){1'b0}}};
        end else begin
            return OUT_W'(s);
        end
`else
        return OUT_W'(s);
`endif
    endfunction

    assign in_ready    = (state_r == ST_LOAD);
    assign accept_s    = in_valid & (state_r == ST_LOAD);
    assign calc_last_s = (state_r == ST_CALC) && (stage_r == 3'd4) && (bfly_r == 4'd15);

    // Butterfly addressing for stage s, butterfly b.
    assign pos_s    = bfly_r & 4'((5'd1 << stage_r) - 5'd1);
    assign top_s    = (({1'b0, bfly_r} >> stage_r) << (stage_r + 3'd1)) + {1'b0, pos_s};
    assign bot_s    = top_s + (5'd1 << stage_r);
    assign tw_idx_s = pos_s << (3'd4 - stage_r);

    assign ext_re_s = {{(W - IN_W - DECIMAL){din_r[IN_W-1]}}, din_r, {DECIMAL{1'b0}}};
    assign ext_im_s = {{(W - IN_W - DECIMAL){din_i[IN_W-1]}}, din_i, {DECIMAL{1'b0}}};

    assign conv_re_s = to_out(buf_re_r[cnt_r]);
    assign conv_im_s = to_out(buf_im_r[cnt_r]);

    ifft32_bfly #(.W(W), .DECIMAL(DECIMAL)) u_bfly (
        .a_re   (buf_re_r[top_s]),
        .a_im   (buf_im_r[top_s]),
        .b_re   (buf_re_r[bot_s]),
        .b_im   (buf_im_r[bot_s]),
        .w_re   (TW_COS[tw_idx_s]),
        .w_im   (TW_SIN[tw_idx_s]),
        .top_re (top_re_s),
        .top_im (top_im_s),
        .bot_re (bot_re_s),
        .bot_im (bot_im_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_LOAD;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic: 32 accepts, 80 butterflies, 32 output cycles.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_LOAD: begin
                if (accept_s && (cnt_r == 5'd31)) next_state_s = ST_CALC;
                else                              next_state_s = ST_LOAD;
            end
            ST_CALC: begin
                if (calc_last_s) next_state_s = ST_DUMP;
                else             next_state_s = ST_CALC;
            end
            ST_DUMP: begin
                if (cnt_r == 5'd0) next_state_s = ST_LOAD;
                else               next_state_s = ST_DUMP;
            end
            default: next_state_s = ST_LOAD;
        endcase
    end

    // Counters and sample buffer: bit-reversed load, in-place butterflies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= 5'd0;
            stage_r <= 3'd0;
            bfly_r  <= 4'd0;
            for (int i = 0; i < N; i++) begin
                buf_re_r[i] <= '0;
                buf_im_r[i] <= '0;
            end
        end else begin
            case (state_r)
                ST_LOAD: begin
                    if (accept_s) begin
                        buf_re_r[bitrev5(cnt_r)] <= ext_re_s;
                        buf_im_r[bitrev5(cnt_r)] <= ext_im_s;
                        cnt_r <= cnt_r + 5'd1;
                    end
                end
                ST_CALC: begin
                    buf_re_r[top_s] <= top_re_s;
                    buf_im_r[top_s] <= top_im_s;
                    buf_re_r[bot_s] <= bot_re_s;
                    buf_im_r[bot_s] <= bot_im_s;
                    if (bfly_r == 4'd15) begin
                        bfly_r  <= 4'd0;
                        stage_r <= calc_last_s ? 3'd0 : stage_r + 3'd1;
                    end else begin
                        bfly_r <= bfly_r + 4'd1;
                    end
                    // Output 0 is presented as CALC ends, so DUMP starts at index 1.
                    if (calc_last_s) cnt_r <= 5'd1;
                end
                ST_DUMP: begin
                    // cnt wraps 31 -> 0 and rests at 0 for the next LOAD.
                    if (cnt_r != 5'd0) cnt_r <= cnt_r + 5'd1;
                end
                default: begin
                    cnt_r <= 5'd0;
                end
            endcase
        end
    end

    // Registered output stage; dout holds its last value after the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            dout_re_r   <= '0;
            dout_im_r   <= '0;
        end else begin
            case (state_r)
                ST_CALC: begin
                    if (calc_last_s) begin
                        out_valid_r <= 1'b1;
                        dout_re_r   <= conv_re_s;
                        dout_im_r   <= conv_im_s;
                    end
                end
                ST_DUMP: begin
                    if (cnt_r == 5'd0) begin
                        out_valid_r <= 1'b0;
                    end else begin
                        dout_re_r <= conv_re_s;
                        dout_im_r <= conv_im_s;
                    end
                end
                default: out_valid_r <= 1'b0;
            endcase
        end
    end

    assign out_valid = out_valid_r;
    assign dout_r    = dout_re_r;
    assign dout_i    = dout_im_r;

endmodule

// File: tb/tb_ifft32_iter.sv
// Self-checking bench for ifft32_iter: directed frames plus random frames
// against a textbook fixed-point inverse FFT model.
module tb_ifft32_iter;

    logic               clk      = 1'b0;
    logic               rst_n    = 1'b0;
    logic               in_valid = 1'b0;
    logic signed [15:0] din_r    = '0;
    logic signed [15:0] din_i    = '0;
    logic               in_ready;
    logic               out_valid;
    logic signed [11:0] dout_r;
    logic signed [11:0] dout_i;

    int     cyc      = 0;
    int     n_checks = 0;
    int     n_pass   = 0;
    int     last_acc = 0;
    int     xr [32];
    int     xi [32];
    int     gr [32];
    int     gi [32];
    longint er [32];
    longint ei [32];
    int     tw_c [16];
    int     tw_s [16];

    ifft32_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .din_r     (din_r),
        .din_i     (din_i),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .dout_r    (dout_r),
        .dout_i    (dout_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int brev(input int v);
        int r = 0;
        for (int b = 0; b < 5; b++) if (v[b]) r |= (1 << (4 - b));
        return r;
    endfunction

    function automatic longint reduce(input longint a);
        longint v;
        v = (a + 1024) >>> 11;
`ifdef IFFT_SAT_EN
        if (v > 2047) v = 2047;
        else if (v < -2048) v = -2048;
`else
        v = ((v & 4095) ^ 2048) - 2048;
`endif
        return v;
    endfunction

    // Textbook radix-2 DIT inverse FFT with Q1.6 twiddles and half-up rounding.
    task automatic run_model();
        longint ar [32];
        longint ai [32];
        for (int n = 0; n < 32; n++) begin
            ar[brev(n)] = longint'(xr[n]) * 64;
            ai[brev(n)] = longint'(xi[n]) * 64;
        end
        for (int s = 0; s < 5; s++) begin
            int h = 1 << s;
            for (int k = 0; k < 32; k += 2 * h) begin
                for (int j = 0; j < h; j++) begin
                    int t = j * (16 / h);
                    int p = k + j;
                    int q = k + j + h;
                    longint tr, ti;
                    tr = (ar[q] * tw_c[t] - ai[q] * tw_s[t] + 32) >>> 6;
                    ti = (ar[q] * tw_s[t] + ai[q] * tw_c[t] + 32) >>> 6;
                    ar[q] = ar[p] - tr;
                    ai[q] = ai[p] - ti;
                    ar[p] = ar[p] + tr;
                    ai[p] = ai[p] + ti;
                end
            end
        end
        for (int n = 0; n < 32; n++) begin
            er[n] = reduce(ar[n]);
            ei[n] = reduce(ai[n]);
        end
    endtask

    task automatic rand_frame(input int amp);
        for (int j = 0; j < 32; j++) begin
            xr[j] = int'($urandom_range(0, 2 * amp)) - amp;
            xi[j] = int'($urandom_range(0, 2 * amp)) - amp;
        end
    endtask

    // Offer samples 0..count-1; gaps drive junk with in_valid low.
    task automatic send(input int count, input bit gaps);
        int j = 0;
        int guard = 0;
        while (j < count && guard < 1000) begin
            @(negedge clk);
            guard++;
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                din_r    = 16'($urandom);
                din_i    = 16'($urandom);
            end else begin
                in_valid = 1'b1;
                din_r    = 16'(xr[j]);
                din_i    = 16'(xi[j]);
                if (in_ready) begin
                    if (j == count - 1) last_acc = cyc;
                    j++;
                end
            end
        end
        if (j < count) check_val("send_timeout", j, count);
    endtask

    // Collect one output frame, check timing/handshake, then compare to the model.
    task automatic receive(input bit hold, input string tag);
        int cnt = 0;
        int guard = 0;
        int bad_ready = 0;
        int first_v = -1;
        while (cnt < 32 && guard < 300) begin
            @(negedge clk);
            guard++;
            if (hold) begin
                in_valid = 1'b1;
                din_r    = 16'($urandom);
                din_i    = 16'($urandom);
                if (in_ready) bad_ready++;
            end else begin
                in_valid = 1'b0;
            end
            if (out_valid) begin
                if (cnt == 0) first_v = cyc;
                gr[cnt] = dout_r;
                gi[cnt] = dout_i;
                cnt++;
            end else if (cnt > 0) begin
                break;
            end
        end
        check_val({tag, "_count"}, cnt, 32);
        check_val({tag, "_latency"}, first_v - last_acc, 81);
        if (hold) check_val({tag, "_ready_busy"}, bad_ready, 0);
        @(negedge clk);
        in_valid = 1'b0;
        check_val({tag, "_valid_end"}, out_valid, 0);
        check_val({tag, "_ready_end"}, in_ready, 1);
        check_val({tag, "_hold_re"}, dout_r, gr[31]);
        for (int n = 0; n < 32; n++) begin
            check_val({tag, "_re"}, gr[n], er[n]);
            check_val({tag, "_im"}, gi[n], ei[n]);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_val("rst_valid", out_valid, 0);
        check_val("rst_ready", in_ready, 1);
        check_val("rst_dout", dout_r, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int quiet;
        for (int k = 0; k < 16; k++) begin
            tw_c[k] = int'($floor($cos(2.0 * 3.14159265358979 * k / 32.0) * 64.0 + 0.5));
            tw_s[k] = int'($floor($sin(2.0 * 3.14159265358979 * k / 32.0) * 64.0 + 0.5));
        end

        repeat (2) @(negedge clk);
        check_val("reset_ready", in_ready, 1);
        check_val("reset_valid", out_valid, 0);
        check_val("reset_dout_r", dout_r, 0);
        check_val("reset_dout_i", dout_i, 0);
        rst_n = 1'b1;

        // DC impulse: every output 64+j0.
        for (int j = 0; j < 32; j++) begin xr[j] = 0; xi[j] = 0; end
        xr[0] = 2048;
        run_model();
        send(32, 1'b0);
        receive(1'b0, "t1");
        for (int n = 0; n < 32; n += 7) begin
            check_val("t1_const_re", gr[n], 64);
            check_val("t1_const_im", gi[n], 0);
        end

        // Single tone at k=1: a rotating phasor of magnitude 100.
        for (int j = 0; j < 32; j++) begin xr[j] = 0; xi[j] = 0; end
        xr[1] = 3200;
        run_model();
        send(32, 1'b0);
        receive(1'b0, "t2");
        check_val("t2_x0_re",  (gr[0]  >= 99   && gr[0]  <= 101),  1);
        check_val("t2_x0_im",  (gi[0]  >= -1   && gi[0]  <= 1),    1);
        check_val("t2_x8_re",  (gr[8]  >= -1   && gr[8]  <= 1),    1);
        check_val("t2_x8_im",  (gi[8]  >= 99   && gi[8]  <= 101),  1);
        check_val("t2_x16_re", (gr[16] >= -101 && gr[16] <= -99),  1);
        check_val("t2_x24_im", (gi[24] >= -101 && gi[24] <= -99),  1);

        // Full-scale DC: saturation vs wrap boundary.
        for (int j = 0; j < 32; j++) begin xr[j] = 32767; xi[j] = 0; end
        run_model();
        send(32, 1'b0);
        receive(1'b0, "t6");
`ifdef IFFT_SAT_EN
        check_val("t6_x0", gr[0], 2047);
`else
        check_val("t6_x0", gr[0], -1);
`endif
        check_val("t6_x1", gr[1], 0);
        check_val("t6_x31", gr[31], 0);

        // Random frames, alternating with input gaps.
        for (int f = 0; f < 30; f++) begin
            rand_frame((f % 3 == 0) ? 14000 : 3000);
            run_model();
            send(32, f[0]);
            receive(1'b0, "rand");
        end

        // in_valid held high through CALC/DUMP; following frame still correct.
        rand_frame(3000);
        run_model();
        send(32, 1'b1);
        receive(1'b1, "t4_hold");
        rand_frame(3000);
        run_model();
        send(32, 1'b0);
        receive(1'b0, "t4_next");

        // Reset in the middle of CALC.
        rand_frame(3000);
        send(32, 1'b0);
        repeat (39) @(negedge clk);
        pulse_reset();
        quiet = 0;
        repeat (150) begin
            @(negedge clk);
            if (out_valid) quiet++;
        end
        check_val("t5_no_output", quiet, 0);

        // Partial frame discarded by reset.
        rand_frame(3000);
        send(10, 1'b0);
        pulse_reset();
        rand_frame(3000);
        run_model();
        send(32, 1'b1);
        receive(1'b0, "t5_after");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
